// File: rtl/my_processor_nios2_oci_trace_capture.sv
// rtl/my_processor_nios2_oci_trace_capture.sv - OCI trace word unpacker with drain FIFO and flush control
module my_processor_nios2_oci_trace_capture #(
  parameter int FIELD_W      = 10,
  parameter int LANES        = 3,
  parameter int COUNT_W      = 4,
  parameter int DEPTH        = 16,
  parameter int DROP_ON_FULL = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [FIELD_W*LANES-1:0]   dct_buffer,
  input  logic [COUNT_W-1:0]         dct_count,
  input  logic                       dct_load,
  output logic                       dct_ready,
  input  logic                       test_ending,
  input  logic                       test_has_ended,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FIELD_W-1:0]         out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                overflow_cnt,
  output logic                       drained
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int SW = FIELD_W * LANES;
  localparam logic [COUNT_W-1:0] LANES_C = COUNT_W'(LANES);
  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);
  localparam logic [LW-1:0]      DEPTH_C = LW'(DEPTH);
  localparam logic [LW-1:0]      LVL_ONE = LW'(1);
  localparam logic [PW-1:0]      PTR_ONE = PW'(1);

  typedef enum logic [1:0] {IDLE, UNPACK, FLUSH, DONE} state_t;

  state_t             state_q, state_d;
  logic [SW-1:0]      stage_q, stage_d;
  logic [COUNT_W-1:0] rem_q, rem_d;
  logic               flush_q, flush_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;
  logic               drained_q, drained_d;
  logic [PW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]      level_q, level_d;
  logic [15:0]        ovf_q, ovf_d;
  logic [FIELD_W-1:0] mem_q [DEPTH];
  logic               push, pop, full, take, advance;

  // Next-state: word capture, lane unpacking with stall/drop, flush sequencing, FIFO bookkeeping
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    rem_d   = rem_q;
    flush_d = flush_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    advance = 1'b0;
    pop     = (level_q != '0) && out_ready;
    full    = (level_q == DEPTH_C);
    take    = dct_load && ready_q;

    case (state_q)
      IDLE: begin
        if (test_ending) flush_d = 1'b1;
        if (take && (dct_count != '0)) begin
          stage_d = dct_buffer;
          rem_d   = (dct_count > LANES_C) ? LANES_C : dct_count;
          state_d = UNPACK;
        end else if (test_ending) begin
          state_d = FLUSH;
        end
      end
      UNPACK: begin
        if (test_ending) flush_d = 1'b1;
        if (!full || pop) begin
          push    = 1'b1;
          advance = 1'b1;
        end else if (DROP_ON_FULL != 0) begin
          advance = 1'b1;
          if (ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
        end
        if (advance) begin
          stage_d = stage_q >> FIELD_W;
          rem_d   = rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) state_d = (flush_q || test_ending) ? FLUSH : IDLE;
        end
      end
      FLUSH: begin
        if (level_q == '0) state_d = DONE;
      end
      default: begin
        state_d = DONE;
      end
    endcase

    if (push) wr_d = wr_q + PTR_ONE;
    if (pop)  rd_d = rd_q + PTR_ONE;
    if (push && !pop)      level_d = level_q + LVL_ONE;
    else if (!push && pop) level_d = level_q - LVL_ONE;

    // Hard stop wins over everything and keeps the drop counter
    if (test_has_ended) begin
      state_d = DONE;
      stage_d = '0;
      rem_d   = '0;
      wr_d    = '0;
      rd_d    = '0;
      level_d = '0;
      push    = 1'b0;
    end

    ready_d   = (state_d == IDLE);
    drained_d = (state_d == DONE);
    valid_d   = (level_d != '0);
  end

  // Control and status registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      stage_q   <= '0;
      rem_q     <= '0;
      flush_q   <= 1'b0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      drained_q <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      level_q   <= '0;
      ovf_q     <= '0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      rem_q     <= rem_d;
      flush_q   <= flush_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      drained_q <= drained_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
    end
  end

  // FIFO storage; cleared on reset so the head reads zero afterwards
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_q] <= stage_q[FIELD_W-1:0];
    end
  end

  assign dct_ready    = ready_q;
  assign out_valid    = valid_q;
  assign out_data     = mem_q[rd_q];
  assign level        = level_q;
  assign overflow_cnt = ovf_q;
  assign drained      = drained_q;

endmodule

// File: tb/tb_my_processor_nios2_oci_trace_capture.sv
// tb/tb_my_processor_nios2_oci_trace_capture.sv - self-checking bench for the trace capture stage
module tb_my_processor_nios2_oci_trace_capture;

  localparam int FW    = 10;
  localparam int LN    = 3;
  localparam int DEPTH = 16;

  logic          clk;
  logic          reset_n;
  logic [29:0]   dct_buffer;
  logic [3:0]    dct_count;
  logic          dct_load;
  logic          dct_ready;
  logic          test_ending;
  logic          test_has_ended;
  logic          out_valid;
  logic          out_ready;
  logic [9:0]    out_data;
  logic [4:0]    level;
  logic [15:0]   overflow_cnt;
  logic          drained;

  // shared stimulus for the two DEPTH=4 instances
  logic [29:0]   s_buffer;
  logic [3:0]    s_count;
  logic          s_load, s_ending, s_ended, s_out_ready;
  logic          a_ready, a_valid, a_drained, b_ready, b_valid, b_drained;
  logic [9:0]    a_data, b_data;
  logic [2:0]    a_level, b_level;
  logic [15:0]   a_ovf, b_ovf;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  my_processor_nios2_oci_trace_capture u_dut (
    .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .dct_load(dct_load), .dct_ready(dct_ready), .test_ending(test_ending),
    .test_has_ended(test_has_ended), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .level(level), .overflow_cnt(overflow_cnt), .drained(drained)
  );

  my_processor_nios2_oci_trace_capture #(.DEPTH(4), .DROP_ON_FULL(0)) u_stall (
    .clk(clk), .reset_n(reset_n), .dct_buffer(s_buffer), .dct_count(s_count),
    .dct_load(s_load), .dct_ready(a_ready), .test_ending(s_ending),
    .test_has_ended(s_ended), .out_valid(a_valid), .out_ready(s_out_ready),
    .out_data(a_data), .level(a_level), .overflow_cnt(a_ovf), .drained(a_drained)
  );

  my_processor_nios2_oci_trace_capture #(.DEPTH(4), .DROP_ON_FULL(1)) u_drop (
    .clk(clk), .reset_n(reset_n), .dct_buffer(s_buffer), .dct_count(s_count),
    .dct_load(s_load), .dct_ready(b_ready), .test_ending(s_ending),
    .test_has_ended(s_ended), .out_valid(b_valid), .out_ready(s_out_ready),
    .out_data(b_data), .level(b_level), .overflow_cnt(b_ovf), .drained(b_drained)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of the default instance: FIFO and pending lanes as queues
  logic [9:0] mq[$];
  logic [9:0] ms[$];
  int  m_phase;      // 0 accepting, 1 flushing, 2 finished
  bit  m_pend, m_ready, m_drained;
  int  m_ovf;

  task automatic model_step();
    bit pop_now, unpacking;
    int pre_sz, pre_phase, n;
    if (!reset_n) begin
      mq.delete(); ms.delete();
      m_phase = 0; m_pend = 0; m_ready = 0; m_drained = 0; m_ovf = 0;
      chk_en = 1;
      return;
    end
    pre_sz    = mq.size();
    pre_phase = m_phase;
    pop_now   = (pre_sz > 0) && out_ready;
    if (test_has_ended) begin
      mq.delete(); ms.delete();
      m_phase = 2; m_ready = 0; m_drained = 1;
      return;
    end
    unpacking = (ms.size() > 0);
    if (pre_phase == 0 && test_ending) m_pend = 1;
    if (pop_now) void'(mq.pop_front());
    if (unpacking) begin
      if (pre_sz < DEPTH || pop_now) mq.push_back(ms.pop_front());
      if (ms.size() == 0 && m_pend) m_phase = 1;
    end else if (pre_phase == 0) begin
      if (dct_load && m_ready && dct_count != 0) begin
        n = (dct_count > LN) ? LN : int'(dct_count);
        for (int i = 0; i < n; i++) ms.push_back(dct_buffer[i*FW +: FW]);
      end else if (test_ending) begin
        m_phase = 1;
      end
    end
    if (pre_phase == 1 && pre_sz == 0) m_phase = 2;
    m_ready   = (m_phase == 0) && (ms.size() == 0);
    m_drained = (m_phase == 2);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of the default instance against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("ready", dct_ready, m_ready);
      check("valid", out_valid, mq.size() > 0);
      check("level", level, mq.size());
      check("ovf", overflow_cnt, m_ovf);
      check("drained", drained, m_drained);
      if (mq.size() > 0) check("data", out_data, mq[0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [29:0] b, input logic [3:0] c);
    int n;
    n = 0;
    while (dct_ready !== 1'b1 && n < 50) begin tick(); n++; end
    check("load_wait", n < 50, 1'b1);
    dct_buffer = b; dct_count = c; dct_load = 1'b1;
    tick();
    dct_load = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (level != '0 && n < 40) begin tick(); n++; end
    check("drain_wait", n < 40, 1'b1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; dct_buffer = '0; dct_count = '0; dct_load = 1'b0;
    test_ending = 1'b0; test_has_ended = 1'b0; out_ready = 1'b0;
    s_buffer = '0; s_count = '0; s_load = 1'b0; s_ending = 1'b0; s_ended = 1'b0; s_out_ready = 1'b0;

    // reset values
    tick(); tick(); tick();
    check("rst_ready", dct_ready, 1'b0);
    check("rst_level", level, 5'd0);
    check("rst_data", out_data, 10'd0);
    check("rst_drained", drained, 1'b0);
    reset_n = 1'b1;
    tick();
    check("post_rst_ready", dct_ready, 1'b1);

    // basic three-lane word with consumer ready
    out_ready = 1'b1;
    load_word({10'h3, 10'h2, 10'h1}, 4'd3);
    check("t1_ready_n", dct_ready, 1'b0);
    tick(); check("t1_d1", out_data, 10'h1); check("t1_v1", out_valid, 1'b1); check("t1_r1", dct_ready, 1'b0);
    tick(); check("t1_d2", out_data, 10'h2); check("t1_r2", dct_ready, 1'b0);
    tick(); check("t1_d3", out_data, 10'h3); check("t1_r3", dct_ready, 1'b1);
    tick(); check("t1_empty", out_valid, 1'b0);

    // count clamped to LANES, then a zero-count load
    load_word({10'h6, 10'h5, 10'h4}, 4'd7);
    tick(); tick(); tick(); tick();
    check("t2_level", level, 5'd0); check("t2_ready", dct_ready, 1'b1);
    load_word({10'h9, 10'h8, 10'h7}, 4'd0);
    check("t2_zero_ready", dct_ready, 1'b1); check("t2_zero_valid", out_valid, 1'b0);

    // stall on full FIFO, then simultaneous push and pop
    out_ready = 1'b0;
    for (int w = 0; w < 6; w++)
      load_word({10'(w*3 + 8'h22), 10'(w*3 + 8'h21), 10'(w*3 + 8'h20)}, 4'd3);
    tick(); tick(); tick(); tick(); tick();
    check("t3_full", level, 5'd16); check("t3_stall_ready", dct_ready, 1'b0);
    out_ready = 1'b1;
    tick();
    check("t3_pushpop", level, 5'd16); check("t3_head", out_data, 10'h21);
    drain();

    // flush requested mid-unpack with five queued
    out_ready = 1'b0;
    load_word({10'h33, 10'h32, 10'h31}, 4'd3);
    load_word({10'h36, 10'h35, 10'h34}, 4'd3);
    tick(); tick();
    check("t4_five", level, 5'd5);
    test_ending = 1'b1; tick(); test_ending = 1'b0;
    check("t4_six", level, 5'd6); check("t4_ready", dct_ready, 1'b0); check("t4_nodrain", drained, 1'b0);
    dct_buffer = {10'h3F, 10'h3E, 10'h3D}; dct_count = 4'd3; dct_load = 1'b1;
    tick(); dct_load = 1'b0;
    check("t4_ignored", level, 5'd6);
    drain();
    check("t4_drained_early", drained, 1'b0);
    tick();
    check("t4_drained", drained, 1'b1);

    // hard stop with six queued
    do_reset();
    out_ready = 1'b0;
    load_word({10'h43, 10'h42, 10'h41}, 4'd3);
    load_word({10'h46, 10'h45, 10'h44}, 4'd3);
    tick(); tick(); tick();
    check("t5_six", level, 5'd6);
    test_has_ended = 1'b1; tick(); test_has_ended = 1'b0;
    check("t5_level", level, 5'd0); check("t5_valid", out_valid, 1'b0);
    check("t5_drained", drained, 1'b1); check("t5_ovf", overflow_cnt, 16'd0);

    // reset during unpack, then normal operation
    do_reset();
    load_word({10'h53, 10'h52, 10'h51}, 4'd3);
    tick();
    reset_n = 1'b0; tick();
    check("t6_ready", dct_ready, 1'b0); check("t6_level", level, 5'd0);
    check("t6_valid", out_valid, 1'b0); check("t6_data", out_data, 10'd0); check("t6_drained", drained, 1'b0);
    reset_n = 1'b1; tick();
    check("t6_ready_back", dct_ready, 1'b1);
    load_word({10'h63, 10'h62, 10'h61}, 4'd2);
    tick(); tick();
    check("t6_level2", level, 5'd2); check("t6_head", out_data, 10'h61);
    drain();

    // DEPTH=4 instances: stall versus drop
    s_buffer = {10'h3, 10'h2, 10'h1}; s_count = 4'd3; s_load = 1'b1;
    tick(); s_load = 1'b0;
    tick(); tick(); tick();
    check("s_a_l3", a_level, 3'd3); check("s_b_l3", b_level, 3'd3);
    check("s_a_r", a_ready, 1'b1); check("s_b_r", b_ready, 1'b1);
    s_buffer = {10'h6, 10'h5, 10'h4}; s_load = 1'b1;
    tick(); s_load = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    check("s_a_full", a_level, 3'd4); check("s_a_stall", a_ready, 1'b0); check("s_a_ovf", a_ovf, 16'd0);
    check("s_b_full", b_level, 3'd4); check("s_b_ovf", b_ovf, 16'd2); check("s_b_ready", b_ready, 1'b1);
    s_out_ready = 1'b1;
    tick();
    check("s_a_pp", a_level, 3'd4); check("s_a_d", a_data, 10'h2); check("s_a_r1", a_ready, 1'b0);
    check("s_b_pop", b_level, 3'd3); check("s_b_d", b_data, 10'h2);
    tick();
    check("s_a_r2", a_ready, 1'b1); check("s_a_d2", a_data, 10'h3); check("s_b_l2", b_level, 3'd2);
    s_out_ready = 1'b0;
    s_ended = 1'b1; tick(); s_ended = 1'b0;
    check("s_b_end_l", b_level, 3'd0); check("s_b_end_v", b_valid, 1'b0);
    check("s_b_end_d", b_drained, 1'b1); check("s_b_end_ovf", b_ovf, 16'd2);
    check("s_a_end_l", a_level, 3'd0); check("s_a_end_d", a_drained, 1'b1);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
